// File: rtl/led_breath_scheduler_if.sv
// Control/status bundle for led_breath_scheduler: mode writes, realign pulse,
// per-channel LED drive and the brightness-step tick.
interface led_breath_scheduler_if #(
   parameter int N = 4
);
   logic         weI;
   logic [1:0]   chI;
   logic [1:0]   modeI;
   logic         syncI;
   logic [N-1:0] ledO;
   logic         tickO;

   modport master (output weI, chI, modeI, syncI, input ledO, tickO);
   modport slave  (input weI, chI, modeI, syncI, output ledO, tickO);
endinterface

// File: rtl/led_breath_scheduler.sv
// Multi-channel LED scheduler: OFF/ON/BREATH/BLINK per channel over a shared
// 11-bit PWM counter, with a prescaled brightness step and a realign pulse.
module led_breath_scheduler #(
   parameter int N      = 4,
   parameter int DIV    = 5859,
   parameter int SPREAD = 512
) (
   input logic                   clkI,
   input logic                   rstI,
   led_breath_scheduler_if.slave bus
);
   localparam logic [1:0]  MODE_OFF    = 2'd0;
   localparam logic [1:0]  MODE_ON     = 2'd1;
   localparam logic [1:0]  MODE_BREATH = 2'd2;
   localparam logic [1:0]  MODE_BLINK  = 2'd3;
   localparam logic [15:0] PRESC_MAX   = 16'(DIV - 1);

   logic [10:0]  pwm_q, pwm_d;
   logic [15:0]  presc_q, presc_d;
   logic [1:0]   mode_q  [N];
   logic [1:0]   mode_d  [N];
   logic [10:0]  level_q [N];
   logic [10:0]  level_d [N];
   logic         dir_q   [N];
   logic         dir_d   [N];
   logic [N-1:0] led_q, led_d;
   logic         tick;

   function automatic logic [10:0] phase(input int unsigned ch);
      phase = 11'((ch * SPREAD) % 2048);
   endfunction

   always_comb begin
      tick    = (presc_q == PRESC_MAX);
      pwm_d   = bus.syncI ? '0 : pwm_q + 11'd1;
      presc_d = (bus.syncI || tick) ? '0 : presc_q + 16'd1;
      led_d   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         mode_d[i]  = mode_q[i];
         level_d[i] = level_q[i];
         dir_d[i]   = dir_q[i];

         case (mode_q[i])
            MODE_OFF:    led_d[i] = 1'b0;
            MODE_ON:     led_d[i] = 1'b1;
            MODE_BREATH: led_d[i] = (level_q[i] > pwm_q);
            default:     led_d[i] = level_q[i][10];
         endcase

         // A write to this channel pre-empts its tick step, even when the mode is unchanged.
         if (bus.weI && bus.chI == 2'(i)) begin
            if (bus.modeI != mode_q[i]) begin
               mode_d[i]  = bus.modeI;
               level_d[i] = bus.modeI[1] ? phase(i) : '0;
               dir_d[i]   = 1'b1;
            end
         end else if (tick && mode_q[i] == MODE_BREATH) begin
            if (dir_q[i]) begin
               if (level_q[i] == '1) begin
                  level_d[i] = 11'd2046;
                  dir_d[i]   = 1'b0;
               end else begin
                  level_d[i] = level_q[i] + 11'd1;
               end
            end else if (level_q[i] == '0) begin
               level_d[i] = 11'd1;
               dir_d[i]   = 1'b1;
            end else begin
               level_d[i] = level_q[i] - 11'd1;
            end
         end else if (tick && mode_q[i] == MODE_BLINK) begin
            level_d[i] = level_q[i] + 11'd1;
         end

         // Realign sees the freshly written mode, so write+sync lands on the phase value.
         if (bus.syncI && mode_d[i][1]) begin
            level_d[i] = phase(i);
            dir_d[i]   = 1'b1;
         end
      end
   end

   always_ff @(posedge clkI) begin
      if (rstI) begin
         pwm_q   <= '0;
         presc_q <= '0;
         led_q   <= '0;
         for (int unsigned i = 0; i < N; i++) begin
            mode_q[i]  <= MODE_OFF;
            level_q[i] <= '0;
            dir_q[i]   <= 1'b1;
         end
      end else begin
         pwm_q   <= pwm_d;
         presc_q <= presc_d;
         led_q   <= led_d;
         for (int unsigned i = 0; i < N; i++) begin
            mode_q[i]  <= mode_d[i];
            level_q[i] <= level_d[i];
            dir_q[i]   <= dir_d[i];
         end
      end
   end

   assign bus.ledO  = led_q;
   assign bus.tickO = tick;
endmodule

// File: tb/tb_led_breath_scheduler.sv
// Bench for led_breath_scheduler (N=4, DIV=4, SPREAD=512): fixed vector table
// plus long multi-cycle sequences scored against a triangle-position model.
module tb_led_breath_scheduler;
   localparam int N      = 4;
   localparam int DIV    = 4;
   localparam int SPREAD = 512;

   logic clk = 1'b0;
   logic rst;

   led_breath_scheduler_if #(.N(N)) bus ();

   led_breath_scheduler #(.N(N), .DIV(DIV), .SPREAD(SPREAD)) dut (
      .clkI (clk),
      .rstI (rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] led;
      bit         tick;
      int         id;
   } exp_t;

   typedef struct {
      bit         r;
      bit         we;
      int         ch;
      int         md;
      bit         sy;
      logic [3:0] led;
      bit         tick;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   vec_t tab[25];
   int   n_vec = 0;
   int   n_bad = 0;

   // Model: BREATH keeps a triangle position 0..4093, BLINK a 0..2047 position.
   int         m_pwm, m_presc, tick_cnt;
   int         m_mode[N];
   int         m_pos[N];
   logic [3:0] m_led;

   function automatic int m_level(int i);
      if (m_mode[i] == 2) return (m_pos[i] <= 2047) ? m_pos[i] : 4094 - m_pos[i];
      if (m_mode[i] == 3) return m_pos[i];
      return 0;
   endfunction

   function automatic bit m_up(int i);
      return !(m_mode[i] == 2 && m_pos[i] >= 2048);
   endfunction

   function automatic void model_step(bit r, bit we, int ch, int md, bit sy);
      logic [3:0] led_n;
      bit         tk;
      led_n = '0;
      if (r) begin
         m_pwm = 0; m_presc = 0; m_led = '0;
         for (int i = 0; i < N; i++) begin m_mode[i] = 0; m_pos[i] = 0; end
         return;
      end
      tk = (m_presc == DIV - 1);
      for (int i = 0; i < N; i++) begin
         case (m_mode[i])
            0:       led_n[i] = 1'b0;
            1:       led_n[i] = 1'b1;
            2:       led_n[i] = (m_level(i) > m_pwm);
            default: led_n[i] = (m_pos[i] >= 1024);
         endcase
      end
      for (int i = 0; i < N; i++) begin
         if (we && ch == i) begin
            if (md != m_mode[i]) begin
               m_mode[i] = md;
               m_pos[i]  = (md >= 2) ? (i * SPREAD) % 2048 : 0;
            end
         end else if (tk && m_mode[i] == 2) m_pos[i] = (m_pos[i] + 1) % 4094;
         else if (tk && m_mode[i] == 3)     m_pos[i] = (m_pos[i] + 1) % 2048;
      end
      if (sy) begin
         m_pwm = 0; m_presc = 0;
         for (int i = 0; i < N; i++) if (m_mode[i] >= 2) m_pos[i] = (i * SPREAD) % 2048;
      end else begin
         if (tk) tick_cnt++;
         m_pwm   = (m_pwm + 1) % 2048;
         m_presc = (m_presc + 1) % DIV;
      end
      m_led = led_n;
   endfunction

   task automatic drive(bit r, bit we, int ch, int md, bit sy,
                        bit use_tab, logic [3:0] tled, bit ttick, int id);
      exp_t e;
      @(negedge clk);
      rst       = r;
      bus.weI   = we;
      bus.chI   = 2'(ch);
      bus.modeI = 2'(md);
      bus.syncI = sy;
      model_step(r, we, ch, md, sy);
      e.led  = use_tab ? tled  : m_led;
      e.tick = use_tab ? ttick : (m_presc == DIV - 1);
      e.id   = id;
      sb.push_back(e);
   endtask

   task automatic cyc(bit r, bit we, int ch, int md, bit sy, int id);
      drive(r, we, ch, md, sy, 1'b0, 4'b0000, 1'b0, id);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_lvl(string nm, int ch, int lvl, bit up, int md);
      n_vec++;
      if (dut.level_q[ch] !== 11'(lvl) || dut.dir_q[ch] !== up || dut.mode_q[ch] !== 2'(md)) begin
         n_bad++;
         $display("FAIL %s ch%0d: got mode %0d level %0d up %0d, want mode %0d level %0d up %0d",
                  nm, ch, dut.mode_q[ch], dut.level_q[ch], dut.dir_q[ch], md, lvl, up);
      end
   endtask

   task automatic chk_cnt(string nm);
      n_vec++;
      if (dut.pwm_q !== 11'd0 || dut.presc_q !== 16'd0) begin
         n_bad++;
         $display("FAIL %s: got pwm %0d presc %0d, want pwm 0 presc 0", nm, dut.pwm_q, dut.presc_q);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         n_vec++;
         if (bus.ledO !== mon_e.led || bus.tickO !== mon_e.tick) begin
            n_bad++;
            $display("FAIL vec%0d: ledO=%b tickO=%b, want ledO=%b tickO=%b",
                     mon_e.id, bus.ledO, bus.tickO, mon_e.led, mon_e.tick);
         end
      end
   end

   initial begin
      #3_000_000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; bus.weI = 1'b0; bus.chI = 2'd0; bus.modeI = 2'd0; bus.syncI = 1'b0;
      tick_cnt = 0;
      model_step(1'b1, 1'b0, 0, 0, 1'b0);

      //          r  we ch md sy  led      tick
      tab[0]  = '{1, 0, 0, 0, 0, 4'b0000, 0};
      tab[1]  = '{0, 0, 0, 0, 0, 4'b0000, 0};
      tab[2]  = '{0, 0, 0, 0, 0, 4'b0000, 0};
      tab[3]  = '{0, 0, 0, 0, 0, 4'b0000, 1};
      tab[4]  = '{0, 1, 0, 1, 0, 4'b0000, 0};
      tab[5]  = '{0, 1, 1, 0, 0, 4'b0001, 0};
      tab[6]  = '{0, 0, 0, 0, 0, 4'b0001, 0};
      tab[7]  = '{0, 0, 0, 0, 0, 4'b0001, 1};
      tab[8]  = '{0, 1, 0, 1, 0, 4'b0001, 0};
      tab[9]  = '{1, 1, 1, 1, 1, 4'b0000, 0};
      tab[10] = '{0, 0, 0, 0, 0, 4'b0000, 0};
      tab[11] = '{0, 0, 0, 0, 0, 4'b0000, 0};
      tab[12] = '{0, 1, 0, 1, 1, 4'b0000, 0};
      tab[13] = '{0, 0, 0, 0, 0, 4'b0001, 0};
      tab[14] = '{0, 0, 0, 0, 0, 4'b0001, 0};
      tab[15] = '{0, 0, 0, 0, 0, 4'b0001, 1};
      tab[16] = '{0, 1, 0, 0, 0, 4'b0001, 0};
      tab[17] = '{0, 0, 0, 0, 0, 4'b0000, 0};
      tab[18] = '{0, 1, 2, 3, 0, 4'b0000, 0};
      tab[19] = '{0, 0, 0, 0, 0, 4'b0100, 1};
      tab[20] = '{0, 1, 2, 3, 0, 4'b0100, 0};
      tab[21] = '{0, 0, 0, 0, 0, 4'b0100, 0};
      tab[22] = '{0, 1, 1, 2, 0, 4'b0100, 0};
      tab[23] = '{0, 0, 0, 0, 0, 4'b0110, 1};
      tab[24] = '{0, 0, 0, 0, 0, 4'b0110, 0};

      for (int k = 0; k < 25; k++)
         drive(tab[k].r, tab[k].we, tab[k].ch, tab[k].md, tab[k].sy, 1'b1, tab[k].led, tab[k].tick, k);
      settle();
      chk_lvl("blink_same_write", 2, 1025, 1'b1, 3);

      // Reset then a long idle stretch: LEDs dark, regular ticks.
      cyc(1, 0, 0, 0, 0, 100);
      for (int k = 0; k < 100; k++) cyc(0, 0, 0, 0, 0, 101);

      // BREATH on ch2: climb to the top, then turn around.
      cyc(0, 1, 2, 2, 0, 200);
      settle();
      chk_lvl("breath_load", 2, 1024, 1'b1, 2);
      tick_cnt = 0;
      for (int k = 0; k < 6000 && tick_cnt < 1023; k++) cyc(0, 0, 0, 0, 0, 201);
      settle();
      chk_lvl("breath_top", 2, 2047, 1'b1, 2);
      for (int k = 0; k < 20 && tick_cnt < 1024; k++) cyc(0, 0, 0, 0, 0, 202);
      settle();
      chk_lvl("breath_turn", 2, 2046, 1'b0, 2);
      for (int k = 0; k < 2100; k++) cyc(0, 0, 0, 0, 0, 203);

      // Staggered BREATH writes, then realign.
      cyc(0, 1, 0, 2, 0, 300);
      for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 301);
      cyc(0, 1, 1, 2, 0, 302);
      for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 0, 303);
      cyc(0, 1, 3, 2, 0, 304);
      for (int k = 0; k < 70; k++) cyc(0, 0, 0, 0, 0, 305);
      cyc(0, 0, 0, 0, 1, 306);
      settle();
      chk_lvl("sync_ch0", 0, 0, 1'b1, 2);
      chk_lvl("sync_ch1", 1, 512, 1'b1, 2);
      chk_lvl("sync_ch2", 2, 1024, 1'b1, 2);
      chk_lvl("sync_ch3", 3, 1536, 1'b1, 2);
      chk_cnt("sync_counters");
      for (int k = 0; k < 12; k++) cyc(0, 0, 0, 0, 0, 307);

      // Write ch3 BLINK together with sync.
      cyc(0, 1, 3, 3, 1, 400);
      settle();
      chk_lvl("wsync_ch3", 3, 1536, 1'b1, 3);
      chk_cnt("wsync_counters");
      tick_cnt = 0;
      for (int k = 0; k < 3000 && tick_cnt < 511; k++) cyc(0, 0, 0, 0, 0, 401);
      settle();
      chk_lvl("blink_hi_end", 3, 2047, 1'b1, 3);
      for (int k = 0; k < 20 && tick_cnt < 512; k++) cyc(0, 0, 0, 0, 0, 402);
      settle();
      chk_lvl("blink_wrap", 3, 0, 1'b1, 3);
      for (int k = 0; k < 5000 && tick_cnt < 1536; k++) cyc(0, 0, 0, 0, 0, 403);
      settle();
      chk_lvl("blink_lo_end", 3, 1024, 1'b1, 3);

      // Reset mid-breath discards channel state, overriding write and sync.
      cyc(1, 0, 0, 0, 0, 500);
      cyc(0, 1, 1, 2, 0, 501);
      for (int k = 0; k < 20000 && !(m_level(1) == 900 && !m_up(1)); k++) cyc(0, 0, 0, 0, 0, 502);
      settle();
      chk_lvl("pre_reset", 1, 900, 1'b0, 2);
      cyc(1, 1, 1, 3, 1, 503);
      settle();
      for (int i = 0; i < N; i++) chk_lvl("reset_state", i, 0, 1'b1, 0);
      chk_cnt("reset_counters");
      cyc(0, 1, 1, 2, 0, 504);
      settle();
      chk_lvl("rewrite_breath", 1, 512, 1'b1, 2);
      for (int k = 0; k < 8; k++) cyc(0, 0, 0, 0, 0, 505);
      settle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/led_breath_scheduler.md
LED_BREATH_SCHEDULER -- requirements
Module: led_breath_scheduler

Interface
REQ-001 Parameter N, default 4, number of LED channels (1..4).
REQ-002 Parameter DIV, default 5859, clocks per brightness step (12_000_000/2048); legal range 2..65535.
REQ-003 Parameter SPREAD, default 512, phase offset between adjacent channels in BREATH mode.
REQ-004 clkI  input  1  single system clock; all logic on rising edge.
REQ-005 rstI  input  1  reset; synchronous, active-high.
REQ-006 weI  input  1  single-cycle mode write strobe.
REQ-007 chI  input  2  target channel for weI; values >= N ignored.
REQ-008 modeI  input  2  mode to write: 0 OFF, 1 ON, 2 BREATH, 3 BLINK.
REQ-009 syncI  input  1  single-cycle pulse; realigns all BREATH/BLINK channels.
REQ-010 ledO  output  N  per-channel PWM LED drive, registered.
REQ-011 tickO  output  1  one-cycle pulse on every brightness step.

Function
REQ-012 Shared 11-bit PWM counter SHALL increment by 1 every clock, wrapping 2047->0.
REQ-013 Prescaler SHALL count 0..DIV-1; tickO SHALL be 1 for exactly the cycle prescaler equals DIV-1, then prescaler returns to 0.
REQ-014 Each channel SHALL hold: 2-bit mode, 11-bit level, 1-bit direction (1 = up).
REQ-015 Mode write: on weI=1 with chI<N, channel mode SHALL update at that clock edge; new mode governs ledO from the following cycle onward.
REQ-016 Writing a mode equal to the current mode SHALL leave level and direction unchanged.
REQ-017 Writing BREATH or BLINK from a different mode SHALL load level = (chI*SPREAD) mod 2048, direction = up.
REQ-018 Writing OFF or ON SHALL load level = 0, direction = up.
REQ-019 OFF: ledO bit SHALL be 0; level frozen.
REQ-020 ON: ledO bit SHALL be 1; level frozen.
REQ-021 BREATH: on each tick, level SHALL step +1 when up, -1 when down; at level 2047 while up, direction SHALL become down and level becomes 2046 on that tick; at level 0 while down, direction becomes up and level becomes 1; triangle period 4094 ticks, no wrap-around.
REQ-022 BREATH: ledO bit SHALL be registered (level > pwm counter); level 0 gives constant 0.
REQ-023 BLINK: on each tick level SHALL increment by 1 with 11-bit wrap; ledO bit SHALL equal registered level[10] (50% blink, period 2048 ticks).
REQ-024 ledO SHALL have exactly one cycle of latency from the counter/level values it is computed from.
REQ-025 syncI=1 SHALL, at that edge, reset prescaler and PWM counter to 0 and reload every BREATH/BLINK channel to level = (i*SPREAD) mod 2048, direction up; OFF/ON channels unaffected; no tick step is applied in that cycle.
REQ-026 weI and syncI in the same cycle: the write SHALL be applied first, then sync applies using the newly written mode for channel chI.
REQ-027 weI coinciding with a tick: the written channel SHALL take the load value of REQ-017/018 (no step that cycle); other channels step normally.
REQ-028 weI with chI >= N SHALL have no effect on any state.

Reset
REQ-029 rstI=1 at a clock edge SHALL set: all modes OFF, all levels 0, all directions up, PWM counter 0, prescaler 0, ledO 0, tickO 0.
REQ-030 rstI SHALL override weI and syncI in the same cycle; reset mid-breath discards all channel state.
REQ-031 First tickO after reset release SHALL occur DIV cycles after the first cycle with rstI=0.

Verification (bench DIV=4, N=4, SPREAD=512)
REQ-032 Reset, then idle 100 cycles -> ledO=0000, tickO pulses every 4 cycles, first at cycle 4.
REQ-033 Write ch0 ON, ch1 OFF -> ledO[0]=1 from the second cycle after weI, ledO[1]=0 throughout.
REQ-034 Write ch2 BREATH -> level loads 1024 up; after 1023 ticks level=2047, next tick 2046 direction down; ledO[2] duty in one PWM period equals level/2048 within +-1 count.
REQ-035 Write all channels BREATH at differing times, then pulse syncI -> levels 0/512/1024/1536, prescaler and PWM counter 0, next tickO 4 cycles later.
REQ-036 weI (ch3 BLINK) and syncI same cycle -> ch3 level 1536 up; ledO[3]=1 until 512 ticks later, then 0 for 1024 ticks.
REQ-037 Assert rstI while ch1 BREATH at level 900 down -> next cycle all state per REQ-029; re-write BREATH reloads 512 up.
